// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared decode definitions for the 5-stage core: opcode/funct encodings,
// ALU operation codes, the divide sequencer state type and the control
// bundles passed from D into the ID/EX boundary. Imported by the decode
// pipe, the ALU and the hazard unit.
package decode_ctrl_pipe_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_DIV   = 6'b011010;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_DIV  = 3'b011;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } div_state_e;

   // Everything decoded in D, including the branch bits that never leave D.
   typedef struct packed {
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       bne;
      logic [2:0] alu_ctrl;
      logic       illegal;
      logic       is_div;
   } ctrl_t;

   // Subset held in the ID/EX register.
   typedef struct packed {
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_write;
      logic       mem_to_reg;
      logic [2:0] alu_ctrl;
      logic       illegal;
   } ctrl_e_t;

   localparam ctrl_t   CTRL_NOP   = '0;
   localparam ctrl_e_t CTRL_E_NOP = '0;

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// D/E control bus between the decode stage and the rest of the pipe.
//   master: drives opD, functD, ValidD, FlushE; receives decoded controls
//   slave : the decode pipe; receives D inputs, drives BranchD/BneD and the
//           E-stage controls, divide status and stall
interface decode_ctrl_pipe_if #(
   parameter int ALUC_W = 3
);
   logic [5:0]        opD;
   logic [5:0]        functD;
   logic              ValidD;
   logic              FlushE;
   logic              BranchD;
   logic              BneD;
   logic              RegWriteE;
   logic              RegDstE;
   logic              AluSrcE;
   logic              MemWriteE;
   logic              MemtoRegE;
   logic [ALUC_W-1:0] ALUControlE;
   logic              DivActiveE;
   logic              DivStallD;
   logic              IllegalE;

   modport master (
      output opD, functD, ValidD, FlushE,
      input  BranchD, BneD, RegWriteE, RegDstE, AluSrcE, MemWriteE,
             MemtoRegE, ALUControlE, DivActiveE, DivStallD, IllegalE
   );

   modport slave (
      input  opD, functD, ValidD, FlushE,
      output BranchD, BneD, RegWriteE, RegDstE, AluSrcE, MemWriteE,
             MemtoRegE, ALUControlE, DivActiveE, DivStallD, IllegalE
   );
endinterface

// File: rtl/decode_ctrl_pipe_decode.sv
// Pure combinational op/funct decode for the D stage.
//   op_i, funct_i : instr[31:26], instr[5:0]
//   valid_i       : 0 = bubble, decodes to all-zero and never illegal
//   ctrl_o        : control bundle incl. branch bits, illegal flag, divide flag
module decode_ctrl_pipe_decode
   import decode_ctrl_pipe_pkg::*;
#(
   parameter bit EN_BNE = 1'b1
) (
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   input  logic       valid_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = CTRL_NOP;
      if (valid_i) begin
         case (op_i)
            OP_RTYPE: begin
               ctrl_o.reg_write = 1'b1;
               ctrl_o.reg_dst   = 1'b1;
               case (funct_i)
                  FN_ADD: ctrl_o.alu_ctrl = ALU_ADD;
                  FN_SUB: ctrl_o.alu_ctrl = ALU_SUB;
                  FN_AND: ctrl_o.alu_ctrl = ALU_AND;
                  FN_OR:  ctrl_o.alu_ctrl = ALU_OR;
                  FN_SLT: ctrl_o.alu_ctrl = ALU_SLT;
                  FN_DIV: begin
                     ctrl_o.alu_ctrl = ALU_DIV;
                     ctrl_o.is_div   = 1'b1;
                  end
                  default: begin
                     ctrl_o         = CTRL_NOP;
                     ctrl_o.illegal = 1'b1;
                  end
               endcase
            end
            OP_LW: begin
               ctrl_o.reg_write  = 1'b1;
               ctrl_o.alu_src    = 1'b1;
               ctrl_o.mem_to_reg = 1'b1;
               ctrl_o.alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
               ctrl_o.mem_write = 1'b1;
               ctrl_o.alu_src   = 1'b1;
               ctrl_o.alu_ctrl  = ALU_ADD;
            end
            OP_ADDI: begin
               ctrl_o.reg_write = 1'b1;
               ctrl_o.alu_src   = 1'b1;
               ctrl_o.alu_ctrl  = ALU_ADD;
            end
            OP_BEQ: begin
               ctrl_o.branch   = 1'b1;
               ctrl_o.alu_ctrl = ALU_SUB;
            end
            OP_BNE: begin
               if (EN_BNE) begin
                  ctrl_o.branch   = 1'b1;
                  ctrl_o.bne      = 1'b1;
                  ctrl_o.alu_ctrl = ALU_SUB;
               end else begin
                  ctrl_o.illegal = 1'b1;
               end
            end
            default: ctrl_o.illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode control pipe: D-stage decode, ID/EX control register and the
// multi-cycle divide sequencer that parks a divide in E and stalls F/D.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : slave side of decode_ctrl_pipe_if (D inputs, FlushE,
//                BranchD/BneD, E controls, DivActiveE, DivStallD, IllegalE)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | E loads from D (or bubbles on FlushE) every cycle
//   ST_RUN  | divide parked in E; cnt_q counts down remaining cycles,
//           | E held and F/D stalled until cnt_q reaches 0
module decode_ctrl_pipe
   import decode_ctrl_pipe_pkg::*;
#(
   parameter int ALUC_W     = 3,
   parameter int DIV_CYCLES = 8,
   parameter int CNT_W      = 8,
   parameter bit EN_BNE     = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   decode_ctrl_pipe_if.slave  bus
);

   ctrl_t                dec;
   ctrl_e_t              e_q, e_d;
   div_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 stall;

   decode_ctrl_pipe_decode #(.EN_BNE(EN_BNE)) u_decode (
      .op_i    (bus.opD),
      .funct_i (bus.functD),
      .valid_i (bus.ValidD),
      .ctrl_o  (dec)
   );

   // The final divide cycle (cnt_q == 0) is not a stall: F/D advances and E
   // must load on that edge, otherwise the next D instruction is lost.
   assign stall = (state_q == ST_RUN) && (cnt_q != '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      e_d     = e_q;
      if (stall) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         if (bus.FlushE) begin
            e_d = CTRL_E_NOP;
         end else begin
            e_d.reg_write  = dec.reg_write;
            e_d.reg_dst    = dec.reg_dst;
            e_d.alu_src    = dec.alu_src;
            e_d.mem_write  = dec.mem_write;
            e_d.mem_to_reg = dec.mem_to_reg;
            e_d.alu_ctrl   = dec.alu_ctrl;
            e_d.illegal    = dec.illegal;
            if (dec.is_div && (DIV_CYCLES > 1)) begin
               state_d = ST_RUN;
               cnt_d   = CNT_W'(DIV_CYCLES - 1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         e_q     <= CTRL_E_NOP;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         e_q     <= e_d;
      end
   end

   assign bus.BranchD     = dec.branch;
   assign bus.BneD        = dec.bne;
   assign bus.RegWriteE   = e_q.reg_write & ~stall;
   assign bus.RegDstE     = e_q.reg_dst;
   assign bus.AluSrcE     = e_q.alu_src;
   assign bus.MemWriteE   = e_q.mem_write;
   assign bus.MemtoRegE   = e_q.mem_to_reg;
   assign bus.ALUControlE = ALUC_W'(e_q.alu_ctrl);
   assign bus.IllegalE    = e_q.illegal;
   assign bus.DivActiveE  = (state_q == ST_RUN);
   assign bus.DivStallD   = stall;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: two instances (bne enabled / disabled) share
// one D-side stimulus and are compared every cycle against a reference
// model that tracks the instruction in E and its remaining divide cycles.
module tb_decode_ctrl_pipe;

   localparam int DIVC = 8;

   typedef struct packed {
      logic       rw, rd, as, mw, mr, br, bne;
      logic [2:0] alu;
      logic       ill, div;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decode_ctrl_pipe_if #(.ALUC_W(3)) bus ();
   decode_ctrl_pipe_if #(.ALUC_W(3)) bus_nb ();

   assign bus_nb.opD    = bus.opD;
   assign bus_nb.functD = bus.functD;
   assign bus_nb.ValidD = bus.ValidD;
   assign bus_nb.FlushE = bus.FlushE;

   decode_ctrl_pipe #(.ALUC_W(3), .DIV_CYCLES(DIVC), .CNT_W(8), .EN_BNE(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   decode_ctrl_pipe #(.ALUC_W(3), .DIV_CYCLES(DIVC), .CNT_W(8), .EN_BNE(1'b0)) dut_nb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_nb)
   );

   int   tests = 0;
   int   fails = 0;
   exp_t m_e [2];
   int   m_busy [2];   // cycles the divide still occupies E, counting the current one

   function automatic exp_t dec(logic [5:0] op, logic [5:0] fn, logic v, bit en_bne);
      exp_t e = '0;
      if (!v) return e;
      case (op)
         6'b000000: begin
            e.rw = 1'b1;
            e.rd = 1'b1;
            case (fn)
               6'b100000: e.alu = 3'b010;
               6'b100010: e.alu = 3'b110;
               6'b100100: e.alu = 3'b000;
               6'b100101: e.alu = 3'b001;
               6'b101010: e.alu = 3'b111;
               6'b011010: begin e.alu = 3'b011; e.div = 1'b1; end
               default:   begin e = '0; e.ill = 1'b1; end
            endcase
         end
         6'b100011: begin e.rw = 1'b1; e.as = 1'b1; e.mr = 1'b1; e.alu = 3'b010; end
         6'b101011: begin e.mw = 1'b1; e.as = 1'b1; e.alu = 3'b010; end
         6'b001000: begin e.rw = 1'b1; e.as = 1'b1; e.alu = 3'b010; end
         6'b000100: begin e.br = 1'b1; e.alu = 3'b110; end
         6'b000101: begin
            if (en_bne) begin e.br = 1'b1; e.bne = 1'b1; e.alu = 3'b110; end
            else e.ill = 1'b1;
         end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   task automatic chk(string tag, int k, logic [7:0] obs, logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic check_e();
      for (int k = 0; k < 2; k++) begin
         logic [10:0] ov;
         logic        stall, active;
         stall  = (m_busy[k] > 1);
         active = (DIVC > 1) && (m_busy[k] > 0);
         if (k == 0)
            ov = {bus.RegWriteE, bus.RegDstE, bus.AluSrcE, bus.MemWriteE, bus.MemtoRegE,
                  bus.ALUControlE, bus.IllegalE, bus.DivActiveE, bus.DivStallD};
         else
            ov = {bus_nb.RegWriteE, bus_nb.RegDstE, bus_nb.AluSrcE, bus_nb.MemWriteE, bus_nb.MemtoRegE,
                  bus_nb.ALUControlE, bus_nb.IllegalE, bus_nb.DivActiveE, bus_nb.DivStallD};
         chk("RegWriteE",   k, 8'(ov[10]),  8'(m_e[k].rw && !stall));
         chk("RegDstE",     k, 8'(ov[9]),   8'(m_e[k].rd));
         chk("AluSrcE",     k, 8'(ov[8]),   8'(m_e[k].as));
         chk("MemWriteE",   k, 8'(ov[7]),   8'(m_e[k].mw));
         chk("MemtoRegE",   k, 8'(ov[6]),   8'(m_e[k].mr));
         chk("ALUControlE", k, 8'(ov[5:3]), 8'(m_e[k].alu));
         chk("IllegalE",    k, 8'(ov[2]),   8'(m_e[k].ill));
         chk("DivActiveE",  k, 8'(ov[1]),   8'(active));
         chk("DivStallD",   k, 8'(ov[0]),   8'(stall));
      end
   endtask

   // Called just after a falling edge: drive D, check D-stage outputs,
   // advance one rising edge, check E-stage outputs on the falling edge.
   task automatic step(logic [5:0] op, logic [5:0] fn, logic v, logic f);
      exp_t d0, d1;
      bus.opD    = op;
      bus.functD = fn;
      bus.ValidD = v;
      bus.FlushE = f;
      d0 = dec(op, fn, v, 1'b1);
      d1 = dec(op, fn, v, 1'b0);
      #1;
      chk("BranchD", 0, 8'(bus.BranchD),    8'(d0.br));
      chk("BneD",    0, 8'(bus.BneD),       8'(d0.bne));
      chk("BranchD", 1, 8'(bus_nb.BranchD), 8'(d1.br));
      chk("BneD",    1, 8'(bus_nb.BneD),    8'(d1.bne));
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (m_busy[k] > 1) begin
            m_busy[k]--;
         end else if (f) begin
            m_e[k]    = '0;
            m_busy[k] = 0;
         end else begin
            m_e[k]    = (k == 0) ? d0 : d1;
            m_busy[k] = m_e[k].div ? DIVC : 0;
         end
      end
      @(negedge clk);
      check_e();
   endtask

   task automatic reset_mid();
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         m_e[k]    = '0;
         m_busy[k] = 0;
      end
      check_e();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   localparam logic [5:0] R = 6'b000000;
   localparam logic [5:0] ADD = 6'b100000, DIV = 6'b011010;

   initial begin
      logic [5:0] fns [6];
      int n_stall, n_active, n_rw, n_alu;
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011010};
      for (int k = 0; k < 2; k++) begin
         m_e[k]    = '0;
         m_busy[k] = 0;
      end
      bus.opD = '0; bus.functD = '0; bus.ValidD = 1'b0; bus.FlushE = 1'b0;

      // reset
      @(negedge clk);
      @(negedge clk);
      check_e();
      rst_n = 1'b1;
      step(R, ADD, 1'b1, 1'b0);
      reset_mid();
      step(R, ADD, 1'b1, 1'b0);

      // lw then sw, addi, beq, bne
      step(6'b100011, 6'h15, 1'b1, 1'b0);
      step(6'b101011, 6'h00, 1'b1, 1'b0);
      step(6'b001000, 6'h3f, 1'b1, 1'b0);
      step(6'b000100, 6'h00, 1'b1, 1'b0);
      step(6'b000101, 6'h00, 1'b1, 1'b0);
      step(6'b000101, 6'h00, 1'b0, 1'b0);

      // divide with FlushE during its third cycle
      step(R, DIV, 1'b1, 1'b0);
      n_stall = 0; n_active = 0; n_rw = 0; n_alu = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.DivStallD)  n_stall++;
         if (bus.DivActiveE) n_active++;
         if (bus.DivActiveE && bus.ALUControlE == 3'b011) n_alu++;
         if (bus.DivActiveE && bus.RegWriteE) begin
            n_rw++;
            chk("div_wb_cycle", 0, 8'(i + 1), 8'(DIVC));
         end
         step(R, ADD, (i != 2), (i == 2));
      end
      chk("div_stall_cycles",  0, 8'(n_stall),  8'(DIVC - 1));
      chk("div_active_cycles", 0, 8'(n_active), 8'(DIVC));
      chk("div_alu_held",      0, 8'(n_alu),    8'(DIVC));
      chk("div_wb_pulses",     0, 8'(n_rw),     8'd1);

      // flush in IDLE with add in D
      step(R, ADD, 1'b1, 1'b1);

      // illegal op, then same op as bubble
      step(6'b111111, 6'h00, 1'b1, 1'b0);
      step(6'b111111, 6'h00, 1'b0, 1'b0);
      step(R, 6'b111111, 1'b1, 1'b0);

      // back-to-back divides
      for (int i = 0; i < DIVC + 2; i++) step(R, DIV, 1'b1, 1'b0);
      for (int i = 0; i < DIVC; i++) step(R, ADD, 1'b0, 1'b0);

      // reset during the fourth cycle of a divide
      step(R, DIV, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(R, ADD, 1'b0, 1'b0);
      reset_mid();
      for (int i = 0; i < 3; i++) step(R, ADD, 1'b0, 1'b0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [5:0] op, fn;
         case ($urandom_range(0, 7))
            0, 1:    op = 6'b000000;
            2:       op = 6'b100011;
            3:       op = 6'b101011;
            4:       op = 6'b001000;
            5:       op = 6'b000100;
            6:       op = 6'b000101;
            default: op = 6'($urandom);
         endcase
         if ($urandom_range(0, 7) != 0) fn = fns[$urandom_range(0, 5)];
         else fn = 6'($urandom);
         if ($urandom_range(0, 99) == 0) reset_mid();
         step(op, fn, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
